// File: rtl/fsm_add_subt_ctrl_if.sv
// Control bundle between the add/subtract sequencer, its requester and the datapath.
// The slave modport is the sequencer's view; master is the requester/datapath view.
interface fsm_add_subt_ctrl_if;
  logic       beg_op_i;
  logic       ack_op_i;
  logic       zero_flag_i;
  logic       norm_done_i;
  logic       round_ovf_i;
  logic       load_a_o;
  logic       load_b_o;
  logic       load_c_o;
  logic       load_d_o;
  logic       load_e_o;
  logic       load_f_o;
  logic       norm_shift_o;
  logic       round_o;
  logic       load_g_o;
  logic       zero_result_o;
  logic       busy_o;
  logic       ready_o;
  logic [3:0] state_o;

  modport slave (
    input  beg_op_i, ack_op_i, zero_flag_i, norm_done_i, round_ovf_i,
    output load_a_o, load_b_o, load_c_o, load_d_o, load_e_o, load_f_o,
           norm_shift_o, round_o, load_g_o, zero_result_o, busy_o, ready_o, state_o
  );

  modport master (
    output beg_op_i, ack_op_i, zero_flag_i, norm_done_i, round_ovf_i,
    input  load_a_o, load_b_o, load_c_o, load_d_o, load_e_o, load_f_o,
           norm_shift_o, round_o, load_g_o, zero_result_o, busy_o, ready_o, state_o
  );
endinterface

// File: rtl/fsm_add_subt_ctrl.sv
// Moore sequencer for the floating-point add/subtract datapath stages.
// Optional feature macro: FSM_ZERO_BYPASS_EN enables the equal-magnitude subtraction shortcut to +0.
module fsm_add_subt_ctrl #(
  parameter int W = 32
) (
  input logic                  clk,
  input logic                  rst,
  fsm_add_subt_ctrl_if.slave   ctrl
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] NormLast = CW'(W - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD_OPS  = 4'd1,
    CLASSIFY  = 4'd2,
    EXP_DIFF  = 4'd3,
    ALIGN     = 4'd4,
    ADD_SUB   = 4'd5,
    NORMALIZE = 4'd6,
    ROUND     = 4'd7,
    ZERO      = 4'd8,
    DONE      = 4'd9
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   normCnt_q, normCnt_d;
  logic            renorm_q, renorm_d;
  logic [CW-1:0]   normCntInc;

  // State register plus the normalization counter and one-shot renormalization flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      normCnt_q <= '0;
      renorm_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      normCnt_q <= normCnt_d;
      renorm_q  <= renorm_d;
    end
  end

  // The incremented value counts the current NORMALIZE cycle, so the guard trips after W-1 cycles
  assign normCntInc = normCnt_q + CW'(1);

  // Next-state logic; the counter idles at zero outside NORMALIZE so every entry starts fresh
  always_comb begin
    state_d   = state_q;
    normCnt_d = '0;
    renorm_d  = renorm_q;
    case (state_q)
      IDLE: begin
        if (ctrl.beg_op_i) begin
          state_d  = LOAD_OPS;
          renorm_d = 1'b0;
        end
      end
      LOAD_OPS: state_d = CLASSIFY;
      CLASSIFY: begin
`ifdef FSM_ZERO_BYPASS_EN
        state_d = ctrl.zero_flag_i ? ZERO : EXP_DIFF;
`else
        state_d = EXP_DIFF;
`endif
      end
      EXP_DIFF: state_d = ALIGN;
      ALIGN:    state_d = ADD_SUB;
      ADD_SUB:  state_d = NORMALIZE;
      NORMALIZE: begin
        normCnt_d = normCntInc;
        if (ctrl.norm_done_i || (normCntInc == NormLast)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (ctrl.round_ovf_i && !renorm_q) begin
          renorm_d = 1'b1;
          state_d  = NORMALIZE;
        end else begin
          state_d = DONE;
        end
      end
`ifdef FSM_ZERO_BYPASS_EN
      ZERO: state_d = DONE;
`endif
      DONE: begin
        if (ctrl.ack_op_i) begin
          if (ctrl.beg_op_i) begin
            state_d  = LOAD_OPS;
            renorm_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from the state register only
  always_comb begin
    ctrl.load_a_o      = 1'b0;
    ctrl.load_b_o      = 1'b0;
    ctrl.load_c_o      = 1'b0;
    ctrl.load_d_o      = 1'b0;
    ctrl.load_e_o      = 1'b0;
    ctrl.load_f_o      = 1'b0;
    ctrl.norm_shift_o  = 1'b0;
    ctrl.round_o       = 1'b0;
    ctrl.load_g_o      = 1'b0;
    ctrl.zero_result_o = 1'b0;
    ctrl.ready_o       = 1'b0;
    ctrl.busy_o        = (state_q != IDLE);
    ctrl.state_o       = state_q;
    case (state_q)
      LOAD_OPS: ctrl.load_a_o = 1'b1;
      CLASSIFY: ctrl.load_b_o = 1'b1;
      EXP_DIFF: ctrl.load_c_o = 1'b1;
      ALIGN:    ctrl.load_d_o = 1'b1;
      ADD_SUB:  ctrl.load_e_o = 1'b1;
      NORMALIZE: begin
        ctrl.norm_shift_o = 1'b1;
        ctrl.load_f_o     = 1'b1;
      end
      ROUND: begin
        ctrl.round_o  = 1'b1;
        ctrl.load_g_o = 1'b1;
      end
`ifdef FSM_ZERO_BYPASS_EN
      ZERO: begin
        ctrl.zero_result_o = 1'b1;
        ctrl.load_g_o      = 1'b1;
      end
`endif
      DONE:    ctrl.ready_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_add_subt_ctrl.sv
// Scoreboard bench for fsm_add_subt_ctrl: the driver queues the expected trace/latency/enable
// counts per operation and a negedge monitor compares them when ready_o first rises.
module tb_fsm_add_subt_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fsm_add_subt_ctrl_if bus ();

  fsm_add_subt_ctrl #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus.slave)
  );

  typedef struct {
    string       name;
    int          lat;
    string       trace;
    logic [79:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  // Packs per-operation high-cycle counts: load_a..load_g, norm_shift, round, zero_result
  function automatic logic [79:0] mkCnt(input int a, b, c, d, e, f, g, sh, rd, z);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(sh), 8'(rd), 8'(z)};
  endfunction

  function automatic logic [15:0] outVec();
    return {bus.load_a_o, bus.load_b_o, bus.load_c_o, bus.load_d_o, bus.load_e_o,
            bus.load_f_o, bus.norm_shift_o, bus.round_o, bus.load_g_o, bus.zero_result_o,
            bus.busy_o, bus.ready_o, bus.state_o};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkTrace(input string name, input string actual, input string expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %s, expected %s", name, actual, expected);
  endtask

  task automatic checkVec(input string name, input logic [79:0] actual, input logic [79:0] expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Monitor: tracks each operation from LOAD_OPS entry and scores it at the first ready cycle
  initial begin
    bit          active = 1'b0;
    int          cyc = 0;
    string       trace = "";
    int          oc[10];
    logic [3:0]  prevState = 4'd0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (bus.state_o == 4'd1 && prevState != 4'd1) begin
          active = 1'b1;
          cyc    = 0;
          trace  = "";
          foreach (oc[i]) oc[i] = 0;
        end
        if (active) begin
          cyc++;
          if (cyc == 1 || bus.state_o != prevState) trace = $sformatf("%s%0h", trace, bus.state_o);
          oc[0] += int'(bus.load_a_o);
          oc[1] += int'(bus.load_b_o);
          oc[2] += int'(bus.load_c_o);
          oc[3] += int'(bus.load_d_o);
          oc[4] += int'(bus.load_e_o);
          oc[5] += int'(bus.load_f_o);
          oc[6] += int'(bus.load_g_o);
          oc[7] += int'(bus.norm_shift_o);
          oc[8] += int'(bus.round_o);
          oc[9] += int'(bus.zero_result_o);
          if (bus.ready_o) begin
            active = 1'b0;
            if (expQ.size() == 0) begin
              checkCount++;
              $display("[TB] FAIL sb_pop: got unexpected result, expected no pending operation");
            end else begin
              e = expQ.pop_front();
              checkOutput({e.name, "_latency"}, cyc, e.lat);
              checkTrace({e.name, "_trace"}, trace, e.trace);
              checkVec({e.name, "_enables"},
                       mkCnt(oc[0], oc[1], oc[2], oc[3], oc[4], oc[5], oc[6], oc[7], oc[8], oc[9]),
                       e.cnt);
            end
          end
        end
      end
      prevState = bus.state_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queues the expected response, then pulses beg_op_i (optionally with ack_op_i for back-to-back)
  task automatic applyStimulus(input string name, input int lat, input string trace,
                               input logic [79:0] cnt, input bit withAck);
    exp_t e;
    e.name  = name;
    e.lat   = lat;
    e.trace = trace;
    e.cnt   = cnt;
    expQ.push_back(e);
    bus.beg_op_i = 1'b1;
    bus.ack_op_i = withAck;
    tick();
    bus.beg_op_i = 1'b0;
    bus.ack_op_i = 1'b0;
  endtask

  task automatic waitReady(input string name, input int budget);
    int n = 0;
    while (!bus.ready_o && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, "_ready"}, int'(bus.ready_o), 1);
  endtask

  task automatic ackOp(input string name);
    tick();
    tick();
    checkOutput({name, "_hold"}, int'(bus.ready_o), 1);
    bus.ack_op_i = 1'b1;
    tick();
    bus.ack_op_i = 1'b0;
    checkOutput({name, "_idle"}, int'(bus.state_o), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [79:0] nomCnt;
    nomCnt          = mkCnt(1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
    rst             = 1'b1;
    bus.beg_op_i    = 1'b0;
    bus.ack_op_i    = 1'b0;
    bus.zero_flag_i = 1'b0;
    bus.norm_done_i = 1'b0;
    bus.round_ovf_i = 1'b0;
    tick();
    tick();
    checkOutput("reset_state", int'(bus.state_o), 0);
    checkOutput("reset_outputs", int'(outVec()), 0);
    rst = 1'b0;
    tick();
    checkOutput("idle_hold", int'(bus.state_o), 0);

    // Nominal path with a stray start request in EXP_DIFF that must be ignored
    bus.norm_done_i = 1'b1;
    applyStimulus("nominal", 8, "12345679", nomCnt, 1'b0);
    tick();
    tick();
    bus.beg_op_i = 1'b1;
    tick();
    bus.beg_op_i = 1'b0;
    waitReady("nominal", 20);
    ackOp("nominal");

    bus.zero_flag_i = 1'b1;
`ifdef FSM_ZERO_BYPASS_EN
    applyStimulus("zero", 4, "1289", mkCnt(1, 1, 0, 0, 0, 0, 1, 0, 0, 1), 1'b0);
`else
    applyStimulus("zero_ignored", 8, "12345679", nomCnt, 1'b0);
`endif
    waitReady("zero", 20);
    bus.zero_flag_i = 1'b0;
    ackOp("zero");

    bus.norm_done_i = 1'b0;
    applyStimulus("norm_sat", 38, "12345679", mkCnt(1, 1, 1, 1, 1, 31, 1, 31, 1, 0), 1'b0);
    waitReady("norm_sat", 60);
    ackOp("norm_sat");

    bus.norm_done_i = 1'b1;
    bus.round_ovf_i = 1'b1;
    applyStimulus("renorm", 10, "1234567679", mkCnt(1, 1, 1, 1, 1, 2, 2, 2, 2, 0), 1'b0);
    waitReady("renorm", 20);
    ackOp("renorm");

    // Worst case: both normalization passes saturate, then a back-to-back restart from DONE
    bus.norm_done_i = 1'b0;
    applyStimulus("worst", 70, "1234567679", mkCnt(1, 1, 1, 1, 1, 62, 2, 62, 2, 0), 1'b0);
    waitReady("worst", 100);
    tick();
    checkOutput("worst_hold", int'(bus.ready_o), 1);
    bus.norm_done_i = 1'b1;
    bus.round_ovf_i = 1'b0;
    applyStimulus("b2b", 8, "12345679", nomCnt, 1'b1);
    checkOutput("b2b_state", int'(bus.state_o), 1);
    checkOutput("b2b_ready", int'(bus.ready_o), 0);
    waitReady("b2b", 20);
    ackOp("b2b");

    // Reset in the middle of ADD_SUB aborts the operation
    bus.beg_op_i = 1'b1;
    tick();
    bus.beg_op_i = 1'b0;
    repeat (4) tick();
    checkOutput("pre_reset_state", int'(bus.state_o), 5);
    rst = 1'b1;
    tick();
    checkOutput("mid_reset_state", int'(bus.state_o), 0);
    checkOutput("mid_reset_outputs", int'(outVec()), 0);
    tick();
    checkOutput("mid_reset_busy", int'(bus.busy_o), 0);
    rst = 1'b0;
    tick();
    checkOutput("post_reset_idle", int'(bus.state_o), 0);

    applyStimulus("recover", 8, "12345679", nomCnt, 1'b0);
    waitReady("recover", 20);
    ackOp("recover");

    tick();
    checkOutput("sb_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
